// File: rtl/mem_burst_arbiter.sv
// Shared burst memory behind the cache controllers.
// Round-robin arbitration, one read or write burst at a time.
module mem_burst_arbiter #(
    parameter int mem_depth  = 32,
    parameter int data_width = 32,
    parameter int addr_width = 32,
    parameter int cache_num  = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [cache_num-1:0]             rd_req,
    input  logic [cache_num*addr_width-1:0]  rd_addr,
    input  logic [cache_num*16-1:0]          rd_len,
    output logic [cache_num-1:0]             rd_gnt,
    output logic [data_width-1:0]            rd_data,
    output logic [cache_num-1:0]             rd_valid,
    input  logic [cache_num-1:0]             rd_ready,
    output logic [cache_num-1:0]             rd_done,
    input  logic [cache_num-1:0]             wr_req,
    input  logic [cache_num*addr_width-1:0]  wr_addr,
    input  logic [cache_num*16-1:0]          wr_len,
    input  logic [cache_num*data_width-1:0]  wr_data,
    input  logic [cache_num-1:0]             wr_valid,
    input  logic [cache_num-1:0]             wr_last,
    output logic [cache_num-1:0]             wr_gnt,
    output logic [cache_num-1:0]             wr_ready,
    output logic [cache_num-1:0]             wr_done
);

    localparam int AW = $clog2(mem_depth);
    localparam int CW = (cache_num > 1) ? $clog2(cache_num) : 1;

    typedef enum logic [2:0] {
        IDLE, GRANT, RD_BURST, WR_BURST, DONE
    } state_t;

    state_t                state;
    logic [data_width-1:0] mem [mem_depth];
    logic [CW-1:0]         rr_ptr;
    logic [CW-1:0]         cid;
    logic                  dir_wr;
    logic [AW-1:0]         base;
    logic [15:0]           len;
    logic [15:0]           count;
    logic [AW-1:0]         cur_idx;
    logic [CW-1:0]         win_id;
    logic                  win_found;
    logic                  win_wr;
    logic [CW-1:0]         j;
    logic [cache_num-1:0]  win_oh;
    logic [cache_num-1:0]  cid_oh;
    logic                  unused_ok;

    // wr_last is informational; high address bits are ignored
    assign unused_ok = ^{wr_last, rd_addr, wr_addr};

    assign cur_idx = base + count[AW-1:0];

    // Round-robin scan from rr_ptr; write wins over read in one cache
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_wr    = 1'b0;
        j         = '0;
        for (int k = 0; k < cache_num; k++) begin
            j = CW'((int'(rr_ptr) + k) % cache_num);
            if (!win_found && (wr_req[j] || rd_req[j])) begin
                win_found = 1'b1;
                win_id    = j;
                win_wr    = wr_req[j];
            end
        end
    end

    // One-hot decodes of the scan winner and the latched owner
    always_comb begin
        win_oh         = '0;
        win_oh[win_id] = 1'b1;
        cid_oh         = '0;
        cid_oh[cid]    = 1'b1;
    end

    // Burst FSM with registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            cid      <= '0;
            dir_wr   <= 1'b0;
            base     <= '0;
            len      <= '0;
            count    <= '0;
            rd_gnt   <= '0;
            wr_gnt   <= '0;
            rd_valid <= '0;
            wr_ready <= '0;
            rd_done  <= '0;
            wr_done  <= '0;
            rd_data  <= '0;
        end else begin
            rd_gnt  <= '0;
            wr_gnt  <= '0;
            rd_done <= '0;
            wr_done <= '0;
            unique case (state)
                IDLE: begin
                    if (win_found) begin
                        cid    <= win_id;
                        dir_wr <= win_wr;
                        count  <= '0;
                        if (win_wr) begin
                            base   <= wr_addr[int'(win_id)*addr_width +: AW];
                            len    <= wr_len[int'(win_id)*16 +: 16];
                            wr_gnt <= win_oh;
                        end else begin
                            base   <= rd_addr[int'(win_id)*addr_width +: AW];
                            len    <= rd_len[int'(win_id)*16 +: 16];
                            rd_gnt <= win_oh;
                        end
                        rr_ptr <= (win_id == CW'(cache_num - 1)) ?
                                  '0 : win_id + CW'(1);
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    if (len == 16'd0) begin
                        if (dir_wr) wr_done <= cid_oh;
                        else        rd_done <= cid_oh;
                        state <= DONE;
                    end else if (dir_wr) begin
                        wr_ready <= cid_oh;
                        state    <= WR_BURST;
                    end else begin
                        rd_valid <= cid_oh;
                        rd_data  <= mem[base];
                        state    <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (rd_ready[cid]) begin
                        if (count == len - 16'd1) begin
                            rd_valid <= '0;
                            rd_done  <= cid_oh;
                            state    <= DONE;
                        end else begin
                            count   <= count + 16'd1;
                            rd_data <= mem[cur_idx + AW'(1)];
                        end
                    end
                end
                WR_BURST: begin
                    if (wr_valid[cid]) begin
                        if (count == len - 16'd1) begin
                            wr_ready <= '0;
                            wr_done  <= cid_oh;
                            state    <= DONE;
                        end else begin
                            count <= count + 16'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory array, deliberately not reset
    always_ff @(posedge clk) begin
        if (state == WR_BURST && wr_valid[cid]) begin
            mem[cur_idx] <= wr_data[int'(cid)*data_width +: data_width];
        end
    end

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Bench for mem_burst_arbiter: burst table, corner sequences,
// and random multi-requester rounds against a transaction model.
module tb_mem_burst_arbiter;

    localparam int MD = 32;
    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    rd_req, rd_gnt, rd_valid, rd_ready, rd_done;
    logic [127:0]  rd_addr, wr_addr, wr_data;
    logic [63:0]   rd_len, wr_len;
    logic [31:0]   rd_data;
    logic [3:0]    wr_req, wr_valid, wr_last, wr_gnt, wr_ready, wr_done;

    mem_burst_arbiter #(
        .mem_depth(32), .data_width(32), .addr_width(32), .cache_num(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
        .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_done(rd_done),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_last(wr_last),
        .wr_gnt(wr_gnt), .wr_ready(wr_ready), .wr_done(wr_done)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_mem [MD];
    int          model_rr = 0;
    int          order_c[$];
    bit          order_w[$];
    bit          p_rd[NC], p_wr[NC];
    logic [31:0] a_rd[NC], a_wr[NC];
    int          l_rd[NC], l_wr[NC];

    typedef struct {
        int          c;
        bit          wr;
        logic [31:0] addr;
        int          len;
        logic [31:0] val;
    } vec_t;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] oh(int c);
        logic [3:0] v;
        v = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    task automatic drive_req(int c, bit wr, logic [31:0] a, int l);
        if (wr) begin
            wr_req[c] = 1'b1;
            wr_addr[c*32 +: 32] = a;
            wr_len[c*16 +: 16] = 16'(l);
        end else begin
            rd_req[c] = 1'b1;
            rd_addr[c*32 +: 32] = a;
            rd_len[c*16 +: 16] = 16'(l);
        end
    endtask

    task automatic expect_gnt(int c, bit wr);
        logic [7:0] e;
        e = wr ? {oh(c), 4'b0} : {4'b0, oh(c)};
        chk($sformatf("gnt c%0d w%0d", c, wr), 64'({wr_gnt, rd_gnt}), 64'(e));
        model_rr = (c + 1) % NC;
        order_c.push_back(c);
        order_w.push_back(wr);
    endtask

    // Called at the grant sample; returns at the IDLE cycle after done.
    // mode 0 full rate, 1 random throttle, 2 alternate throttle
    task automatic run_burst(int c, bit wr, logic [31:0] a, int l,
                             int mode, bit has_exp, logic [31:0] val);
        int          beats = 0;
        int          cyc = 0;
        int          idx;
        bit          go;
        logic [31:0] d;
        if (wr) wr_req[c] = 1'b0;
        else    rd_req[c] = 1'b0;
        forever begin
            step();
            cyc++;
            if (cyc > 100) begin
                checks++;
                failures++;
                $display("FAIL timeout c%0d w%0d beats=%0d required=%0d",
                         c, wr, beats, l);
                break;
            end
            go = (mode == 0) ? 1'b1 :
                 (mode == 1) ? 1'($urandom_range(0, 1)) : 1'(cyc % 2 == 0);
            idx = int'((a + 32'(beats)) % MD);
            if (beats < l) begin
                if (wr) begin
                    chk("wr_ready", 64'({wr_ready, wr_done}), 64'({oh(c), 4'b0}));
                    d = has_exp ? val + 32'(beats) : $urandom;
                    wr_valid[c] = go;
                    wr_data[c*32 +: 32] = d;
                    if (go) begin
                        model_mem[idx] = d;
                        beats++;
                    end
                end else begin
                    chk("rd_valid", 64'({rd_valid, rd_done}), 64'({oh(c), 4'b0}));
                    chk("rd_data", 64'(rd_data),
                        64'(has_exp ? val + 32'(beats) : model_mem[idx]));
                    rd_ready[c] = go;
                    if (go) beats++;
                end
            end else begin
                if (wr) chk("wr_done", 64'({wr_done, wr_ready}), 64'({oh(c), 4'b0}));
                else    chk("rd_done", 64'({rd_done, rd_valid}), 64'({oh(c), 4'b0}));
                break;
            end
        end
        wr_valid[c] = 1'b0;
        rd_ready[c] = 1'b0;
        step();
    endtask

    // Drives all pending requests at once and serves them in model order
    task automatic serve_round(int mode);
        int  w;
        bit  ww;
        bit  any;
        for (int c = 0; c < NC; c++) begin
            if (p_wr[c]) drive_req(c, 1'b1, a_wr[c], l_wr[c]);
            if (p_rd[c]) drive_req(c, 1'b0, a_rd[c], l_rd[c]);
        end
        forever begin
            any = 1'b0;
            for (int c = 0; c < NC; c++) any |= p_wr[c] | p_rd[c];
            if (!any) break;
            step();
            w = -1;
            ww = 1'b0;
            for (int k = 0; k < NC; k++) begin
                int c;
                c = (model_rr + k) % NC;
                if (w < 0 && (p_wr[c] || p_rd[c])) begin
                    w = c;
                    ww = p_wr[c];
                end
            end
            expect_gnt(w, ww);
            if (ww) begin
                p_wr[w] = 1'b0;
                run_burst(w, 1'b1, a_wr[w], l_wr[w], mode, 1'b0, '0);
            end else begin
                p_rd[w] = 1'b0;
                run_burst(w, 1'b0, a_rd[w], l_rd[w], mode, 1'b0, '0);
            end
        end
    endtask

    initial begin
        vec_t vt[9];
        vt[0] = '{c: 0, wr: 1, addr: 32'h0,         len: 32, val: 32'h100};
        vt[1] = '{c: 0, wr: 1, addr: 32'h10,        len: 4,  val: 32'hA0};
        vt[2] = '{c: 0, wr: 0, addr: 32'h10,        len: 4,  val: 32'hA0};
        vt[3] = '{c: 2, wr: 1, addr: 32'd30,        len: 4,  val: 32'hB0};
        vt[4] = '{c: 3, wr: 0, addr: 32'h1E,        len: 4,  val: 32'hB0};
        vt[5] = '{c: 1, wr: 0, addr: 32'h20,        len: 2,  val: 32'hB2};
        vt[6] = '{c: 3, wr: 0, addr: 32'hFFFFFF10,  len: 3,  val: 32'hA0};
        vt[7] = '{c: 1, wr: 1, addr: 32'h5,         len: 0,  val: 32'h0};
        vt[8] = '{c: 2, wr: 0, addr: 32'h2,         len: 3,  val: 32'h102};

        rst_n = 1'b0;
        rd_req = '0; rd_addr = '0; rd_len = '0; rd_ready = '0;
        wr_req = '0; wr_addr = '0; wr_len = '0; wr_data = '0;
        wr_valid = '0; wr_last = '0;
        for (int i = 0; i < NC; i++) begin
            p_rd[i] = 0; p_wr[i] = 0;
        end
        step();
        step();
        chk("reset outs", 64'({rd_gnt, rd_valid, rd_done, wr_gnt, wr_ready, wr_done}), 64'(0));
        chk("reset rd_data", 64'(rd_data), 64'(0));
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 9; i++) begin
            drive_req(vt[i].c, vt[i].wr, vt[i].addr, vt[i].len);
            step();
            expect_gnt(vt[i].c, vt[i].wr);
            run_burst(vt[i].c, vt[i].wr, vt[i].addr, vt[i].len, 0, 1'b1, vt[i].val);
        end

        // Backpressure: ready low every other cycle
        drive_req(1, 1'b0, 32'h10, 3);
        step();
        expect_gnt(1, 1'b0);
        run_burst(1, 1'b0, 32'h10, 3, 2, 1'b1, 32'hA0);

        // Write beats read in the same cache
        order_c.delete();
        order_w.delete();
        p_wr[1] = 1; a_wr[1] = 32'h8; l_wr[1] = 2;
        p_rd[1] = 1; a_rd[1] = 32'h8; l_rd[1] = 2;
        serve_round(0);
        chk("wr priority", 64'(order_w[0]), 64'(1));

        // Reset during beat 2 of an 8-beat read
        drive_req(1, 1'b0, 32'h0, 8);
        step();
        expect_gnt(1, 1'b0);
        rd_req[1] = 1'b0;
        step();
        rd_ready[1] = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        chk("midreset outs", 64'({rd_gnt, rd_valid, rd_done, wr_gnt, wr_ready, wr_done}), 64'(0));
        chk("midreset rd_data", 64'(rd_data), 64'(0));
        rd_ready = '0;
        model_rr = 0;
        step();
        step();
        rst_n = 1'b1;
        step();
        p_rd[3] = 1; a_rd[3] = 32'h4; l_rd[3] = 2;
        serve_round(0);

        // Round-robin order
        order_c.delete();
        order_w.delete();
        for (int i = 0; i < NC; i++) begin
            p_rd[i] = 1;
            a_rd[i] = $urandom;
            l_rd[i] = $urandom_range(1, 3);
        end
        serve_round(0);
        for (int i = 0; i < NC; i++) chk("rr order", 64'(order_c[i]), 64'(i));
        order_c.delete();
        p_rd[2] = 1; a_rd[2] = 32'h3; l_rd[2] = 1;
        p_rd[0] = 1; a_rd[0] = 32'h7; l_rd[0] = 1;
        serve_round(0);
        chk("rr 0 first", 64'(order_c[0]), 64'(0));
        chk("rr 2 next", 64'(order_c[1]), 64'(2));

        // Random rounds
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < NC; i++) begin
                p_wr[i] = ($urandom_range(0, 2) == 0);
                p_rd[i] = ($urandom_range(0, 2) == 0);
                a_wr[i] = $urandom;
                a_rd[i] = $urandom;
                l_wr[i] = $urandom_range(0, 6);
                l_rd[i] = $urandom_range(0, 6);
            end
            serve_round(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
